// File: rtl/ddr_serializer_tx.sv
// Word-to-pair serializer feeding an ODDR: shifts out one parallel word as
// WORD_W/2 bit pairs, LSB first, with a one-word holding buffer and idle fill.
module ddr_serializer_tx #(
    parameter int                WORD_W    = 10,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [1:0]        q,
    output logic              word_start,
    output logic              underflow,
    output logic [CNT_W-1:0]  underflow_cnt
);

    localparam int            P      = WORD_W / 2;
    localparam int            PW     = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(P - 1);

    logic [PW-1:0]     p_q, p_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [1:0]        q_q, q_d;
    logic              word_start_q, word_start_d;
    logic              underflow_q, underflow_d;
    logic [CNT_W-1:0]  underflow_cnt_q, underflow_cnt_d;

    logic wrap;
    logic accept;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        wrap      = (p_q == P_LAST);
        // The hold slot frees up at the wrap, so a new word can land there in the same cycle.
        din_ready = !hold_v_q || wrap;
        accept    = din_valid && din_ready;

        p_d             = wrap ? '0 : p_q + 1'b1;
        cur_d           = cur_q;
        hold_d          = hold_q;
        hold_v_d        = hold_v_q;
        q_d             = cur_q[{p_q, 1'b0} +: 2];
        word_start_d    = (p_q == '0);
        underflow_d     = 1'b0;
        underflow_cnt_d = underflow_cnt_q;

        if (wrap) begin
            if (hold_v_q) begin
                cur_d = hold_q;
                if (accept) begin
                    hold_d = din;
                end else begin
                    hold_v_d = 1'b0;
                end
            end else if (accept) begin
                cur_d = din;
            end else begin
                cur_d       = IDLE_WORD;
                underflow_d = 1'b1;
                if (underflow_cnt_q != {CNT_W{1'b1}}) begin
                    underflow_cnt_d = underflow_cnt_q + 1'b1;
                end
            end
        end else if (accept) begin
            hold_d   = din;
            hold_v_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_q             <= '0;
            cur_q           <= IDLE_WORD;
            hold_q          <= '0;
            hold_v_q        <= 1'b0;
            q_q             <= 2'b00;
            word_start_q    <= 1'b0;
            underflow_q     <= 1'b0;
            underflow_cnt_q <= '0;
        end else begin
            p_q             <= p_d;
            cur_q           <= cur_d;
            hold_q          <= hold_d;
            hold_v_q        <= hold_v_d;
            q_q             <= q_d;
            word_start_q    <= word_start_d;
            underflow_q     <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign q             = q_q;
    assign word_start    = word_start_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_ddr_serializer_tx.sv
// Bench for ddr_serializer_tx: accepted words go into a scoreboard queue and
// are compared pair by pair as they leave on q; idle fill is predicted from an empty queue.
module tb_ddr_serializer_tx;

    localparam int         WORD_W = 10;
    localparam int         P      = WORD_W / 2;
    localparam logic [9:0] IDLE   = 10'b1101010100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        resetn_s = 1'b0;
    logic [9:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [1:0]  q;
    logic        word_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    logic        s_din_ready;
    logic [1:0]  s_q;
    logic        s_word_start;
    logic        s_underflow;
    logic [3:0]  s_underflow_cnt;

    always #5 clk = ~clk;

    ddr_serializer_tx dut (
        .clk           (clk),
        .resetn        (resetn),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .q             (q),
        .word_start    (word_start),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    ddr_serializer_tx #(.CNT_W(4)) dut_s (
        .clk           (clk),
        .resetn        (resetn_s),
        .din           (10'h000),
        .din_valid     (1'b0),
        .din_ready     (s_din_ready),
        .q             (s_q),
        .word_start    (s_word_start),
        .underflow     (s_underflow),
        .underflow_cnt (s_underflow_cnt)
    );

    int          total = 0;
    int          bad = 0;
    logic [9:0]  pend_q[$];
    logic [9:0]  cur_exp = IDLE;
    int          ph = 0;
    logic [15:0] cnt_exp = '0;

    // One clock: record acceptance, clock, then compare every output at negedge.
    task automatic step();
        bit         acc;
        int         oldph;
        logic [1:0] qe;
        logic       uf_e;
        acc = resetn && din_valid && din_ready;
        if (acc) pend_q.push_back(din);
        @(posedge clk);
        @(negedge clk);
        if (!resetn) begin
            total++;
            if (q !== 2'b00 || word_start !== 1'b0 || underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
                bad++;
                $display("FAIL reset_outputs t=%0t got q=%b ws=%b uf=%b cnt=%0d expected all zero",
                         $time, q, word_start, underflow, underflow_cnt);
            end
            pend_q.delete();
            cur_exp = IDLE;
            ph      = 0;
            cnt_exp = '0;
        end else begin
            oldph = ph;
            qe    = cur_exp[2*oldph +: 2];
            uf_e  = (oldph == P - 1) && (pend_q.size() == 0);
            total++;
            if (q !== qe) begin
                bad++;
                $display("FAIL q_pair t=%0t phase=%0d word=%h got %b expected %b", $time, oldph, cur_exp, q, qe);
            end
            total++;
            if (word_start !== (oldph == 0)) begin
                bad++;
                $display("FAIL word_start t=%0t phase=%0d got %b expected %b", $time, oldph, word_start, (oldph == 0));
            end
            total++;
            if (underflow !== uf_e) begin
                bad++;
                $display("FAIL underflow t=%0t phase=%0d got %b expected %b", $time, oldph, underflow, uf_e);
            end
            if (oldph == P - 1) begin
                if (uf_e) begin
                    cur_exp = IDLE;
                    if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
                end else begin
                    cur_exp = pend_q.pop_front();
                end
            end
            total++;
            if (underflow_cnt !== cnt_exp) begin
                bad++;
                $display("FAIL underflow_cnt t=%0t got %0d expected %0d", $time, underflow_cnt, cnt_exp);
            end
            ph = (oldph == P - 1) ? 0 : oldph + 1;
        end
    endtask

    task automatic idle_until(input int target);
        din_valid = 1'b0;
        for (int i = 0; i < 2 * P && ph != target; i++) step();
        total++;
        if (ph != target) begin
            bad++;
            $display("FAIL phase_wait got %0d expected %0d", ph, target);
        end
    endtask

    task automatic drain();
        din_valid = 1'b0;
        for (int i = 0; i < 6 * P && pend_q.size() != 0; i++) step();
        total++;
        if (pend_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d expected 0", pend_q.size());
        end
        repeat (P) step();
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        din_valid = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_idle();
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (underflow === 1'b1) n++;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL idle_pulses got %0d expected 4", n);
        end
        total++;
        if (underflow_cnt !== 16'd4) begin
            bad++;
            $display("FAIL idle_count got %0d expected 4", underflow_cnt);
        end
    endtask

    task automatic test_stream();
        logic rdy;
        int   pb;
        int   ufs = 0;
        int   nrdy = 0;
        din       = 10'h001;
        din_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy = din_ready;
            pb  = ph;
            if (i >= 1) begin
                total++;
                if (rdy !== (pb == P - 1)) begin
                    bad++;
                    $display("FAIL stream_ready i=%0d phase=%0d got %b expected %b", i, pb, rdy, (pb == P - 1));
                end
            end
            step();
            if (underflow === 1'b1) ufs++;
            if (rdy === 1'b1) begin
                nrdy++;
                din = din + 10'd1;
            end
        end
        total++;
        if (ufs != 0) begin
            bad++;
            $display("FAIL stream_underflow got %0d expected 0", ufs);
        end
        total++;
        if (nrdy != 9) begin
            bad++;
            $display("FAIL stream_accepts got %0d expected 9", nrdy);
        end
        drain();
    endtask

    task automatic test_hold();
        idle_until(1);
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_ready_first got %b expected 1", din_ready);
        end
        din       = 10'h3FF;
        din_valid = 1'b1;
        step();
        din = 10'h0AB;
        for (int k = 0; k < 2 * P && ph != P - 1; k++) begin
            total++;
            if (din_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stall phase=%0d got %b expected 0", ph, din_ready);
            end
            step();
        end
        total++;
        if (din_ready !== 1'b1 || ph != P - 1) begin
            bad++;
            $display("FAIL hold_release phase=%0d got %b expected 1", ph, din_ready);
        end
        step();
        drain();
    endtask

    task automatic test_bypass();
        idle_until(P - 1);
        din       = 10'h155;
        din_valid = 1'b1;
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ready got %b expected 1", din_ready);
        end
        step();
        din_valid = 1'b0;
        step();
        total++;
        if (q !== 2'b01 || word_start !== 1'b1) begin
            bad++;
            $display("FAIL bypass_first_pair got q=%b ws=%b expected q=01 ws=1", q, word_start);
        end
        drain();
    endtask

    task automatic test_reset_midword();
        idle_until(P - 1);
        din       = 10'h2AA;
        din_valid = 1'b1;
        step();
        idle_until(2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        total++;
        if (underflow_cnt !== 16'd0 || word_start !== 1'b1) begin
            bad++;
            $display("FAIL restart got cnt=%0d ws=%b expected cnt=0 ws=1", underflow_cnt, word_start);
        end
        repeat (2 * P) step();
    endtask

    task automatic test_saturation();
        logic [3:0] prev;
        resetn_s = 1'b0;
        step();
        resetn_s = 1'b1;
        total++;
        if (s_underflow_cnt !== 4'd0) begin
            bad++;
            $display("FAIL sat_reset got %0d expected 0", s_underflow_cnt);
        end
        prev = 4'd0;
        for (int i = 0; i < 100 * P; i++) begin
            step();
            total++;
            if (s_underflow_cnt < prev) begin
                bad++;
                $display("FAIL sat_monotonic i=%0d got %0d after %0d", i, s_underflow_cnt, prev);
            end
            prev = s_underflow_cnt;
            if (i == 15 * P - 2) begin
                total++;
                if (s_underflow_cnt !== 4'd14) begin
                    bad++;
                    $display("FAIL sat_before got %0d expected 14", s_underflow_cnt);
                end
            end
        end
        total++;
        if (s_underflow_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_final got %0d expected 15", s_underflow_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_stream();
        test_hold();
        test_bypass();
        test_reset_midword();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
